// File: rtl/dstm_fifo_engine.sv
// FX2 synchronous slave-FIFO engine: turns FLAGA/FLAGB/SLRD/SLWR traffic into rx/tx byte streams.
// Optional build macro DSTM_BYTE_COUNT_EN adds free-running rx_count/tx_count strobe counters.
module dstm_fifo_engine #(
    parameter int BURST_LEN   = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic       IFCLK,
    input  logic       RST,
    input  logic       EPPRST,
    input  logic       STMEN,
    input  logic       FLAGA,
    input  logic       FLAGB,
    output logic       SLRD,
    output logic       SLWR,
    output logic       SLOE,
    output logic [1:0] FIFOADR,
    output logic       PKTEND,
    input  logic [7:0] DB_I,
    output logic [7:0] DB_O,
    output logic [7:0] DB_T,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_flush,
    output logic       busy
`ifdef DSTM_BYTE_COUNT_EN
    ,
    output logic [31:0] rx_count,
    output logic [31:0] tx_count
`endif
);

    typedef enum logic [2:0] {IDLE, TURN, RD, WR, FLUSH} state_t;
    typedef enum logic {DIR_RX, DIR_TX} dir_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    state_t     state;
    dir_t       target;
    dir_t       last_dir;
    logic [7:0] burst_cnt;
    logic [1:0] turn_cnt;
    logic       flush_pend;

    logic go;
    logic rd_req;
    logic wr_req;
    logic pick_tx;
    logic rx_hold;
    logic burst_done;
    logic tx_fire;

    assign go         = STMEN & ~EPPRST;
    assign rd_req     = go & ~FLAGA & ~rx_valid;
    assign wr_req     = go & ~FLAGB & (tx_valid | flush_pend);
    // Round-robin: on contention serve the direction opposite to the last one.
    assign pick_tx    = wr_req & (~rd_req | (last_dir == DIR_RX));
    assign rx_hold    = rx_valid & ~rx_ready;
    assign burst_done = (burst_cnt == BURST_MAX);
    assign tx_ready   = (state == WR) & ~FLAGB & SLWR & go & ~burst_done;
    assign tx_fire    = tx_valid & tx_ready;
    assign busy       = (state != IDLE);

    // NOTE: every registered signal here uses <= so all reads within a cycle see the pre-edge values.
    always_ff @(posedge IFCLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            target     <= DIR_TX;
            last_dir   <= DIR_TX;
            burst_cnt  <= '0;
            turn_cnt   <= '0;
            flush_pend <= 1'b0;
            SLRD       <= 1'b1;
            SLWR       <= 1'b1;
            SLOE       <= 1'b1;
            PKTEND     <= 1'b1;
            FIFOADR    <= 2'b00;
            DB_O       <= 8'h00;
            DB_T       <= 8'hFF;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
        end else begin
            if (tx_flush)
                flush_pend <= 1'b1;
            else if (state == FLUSH)
                flush_pend <= 1'b0;

            // A capture further down overrides this clear; it never coincides with a held byte.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        state     <= TURN;
                        turn_cnt  <= '0;
                        burst_cnt <= '0;
                        target    <= pick_tx ? DIR_TX : DIR_RX;
                        last_dir  <= pick_tx ? DIR_TX : DIR_RX;
                        FIFOADR   <= pick_tx ? 2'b10 : 2'b00;
                        SLOE      <= pick_tx;
                    end
                end
                TURN: begin
                    if (!go) begin
                        state <= IDLE;
                        SLOE  <= 1'b1;
                    end else if (turn_cnt == TURN_LAST) begin
                        if (target == DIR_TX) begin
                            state <= WR;
                            DB_T  <= 8'h00;
                        end else begin
                            state <= RD;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
                RD: begin
                    // SLRD high is the gap/decision cycle; SLRD low is the strobe cycle.
                    if (!SLRD) begin
                        rx_data   <= DB_I;
                        rx_valid  <= 1'b1;
                        burst_cnt <= burst_cnt + 8'd1;
                        SLRD      <= 1'b1;
                        if (!go) begin
                            state <= IDLE;
                            SLOE  <= 1'b1;
                        end
                    end else if (FLAGA || burst_done || !go || rx_hold) begin
                        state <= IDLE;
                        SLOE  <= 1'b1;
                    end else begin
                        SLRD <= 1'b0;
                    end
                end
                WR: begin
                    if (!SLWR) begin
                        SLWR <= 1'b1;
                        if (!go) begin
                            state <= IDLE;
                            DB_T  <= 8'hFF;
                        end
                    end else if (tx_fire) begin
                        DB_O      <= tx_data;
                        SLWR      <= 1'b0;
                        burst_cnt <= burst_cnt + 8'd1;
                    end else if (go && flush_pend) begin
                        state  <= FLUSH;
                        PKTEND <= 1'b0;
                    end else begin
                        state <= IDLE;
                        DB_T  <= 8'hFF;
                    end
                end
                FLUSH: begin
                    PKTEND <= 1'b1;
                    DB_T   <= 8'hFF;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DSTM_BYTE_COUNT_EN
    always_ff @(posedge IFCLK or posedge RST) begin
        if (RST) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (!SLRD)
                rx_count <= rx_count + 32'd1;
            if (!SLWR)
                tx_count <= tx_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dstm_fifo_engine.sv
// Bench for dstm_fifo_engine: cycle table for the read path, FX2 FIFO model for the rest.
module tb_dstm_fifo_engine;

    localparam int BURST = 4;

    logic       IFCLK = 1'b0;
    logic       RST;
    logic       EPPRST;
    logic       STMEN;
    logic       FLAGA;
    logic       FLAGB;
    logic       SLRD;
    logic       SLWR;
    logic       SLOE;
    logic [1:0] FIFOADR;
    logic       PKTEND;
    logic [7:0] DB_I;
    logic [7:0] DB_O;
    logic [7:0] DB_T;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_flush;
    logic       busy;
`ifdef DSTM_BYTE_COUNT_EN
    logic [31:0] rx_count;
    logic [31:0] tx_count;
`endif

    logic       model_en;
    logic       flaga_tb;
    logic       flagb_tb;
    logic [7:0] db_i_tb;
    logic       limit_en;
    int         wr_limit;
    logic       tx_en;

    logic [7:0] out_mem [64];
    int         out_wr = 0;
    int         out_rd = 0;
    logic [7:0] tx_mem [64];
    int         tx_wr = 0;
    int         tx_rd = 0;

    int         cyc = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         pkt_cnt = 0;
    int         viol = 0;
    int         last_wr_cyc = 0;
    int         last_pkt_cyc = 0;
    logic       prev_pkt_low = 1'b0;
    logic [7:0] wr_log [$];
    logic [7:0] rx_log [$];
    logic       dir_log [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign FLAGA    = model_en ? (out_rd == out_wr) : flaga_tb;
    assign DB_I     = model_en ? out_mem[out_rd % 64] : db_i_tb;
    assign FLAGB    = flagb_tb | (limit_en && (wr_cnt >= wr_limit));
    assign tx_valid = tx_en && (tx_rd != tx_wr);
    assign tx_data  = tx_mem[tx_rd % 64];

    dstm_fifo_engine #(.BURST_LEN(BURST), .TURN_CYCLES(1)) u_dut (
        .IFCLK    (IFCLK),
        .RST      (RST),
        .EPPRST   (EPPRST),
        .STMEN    (STMEN),
        .FLAGA    (FLAGA),
        .FLAGB    (FLAGB),
        .SLRD     (SLRD),
        .SLWR     (SLWR),
        .SLOE     (SLOE),
        .FIFOADR  (FIFOADR),
        .PKTEND   (PKTEND),
        .DB_I     (DB_I),
        .DB_O     (DB_O),
        .DB_T     (DB_T),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_flush (tx_flush),
        .busy     (busy)
`ifdef DSTM_BYTE_COUNT_EN
        ,
        .rx_count (rx_count),
        .tx_count (tx_count)
`endif
    );

    always #5 IFCLK = ~IFCLK;

    // FX2 side model plus bus-protocol monitor; sees the values held during the ending cycle.
    always @(posedge IFCLK) begin
        cyc          <= cyc + 1;
        prev_pkt_low <= !PKTEND;
        if (!RST) begin
            if (!SLRD) begin
                rd_cnt <= rd_cnt + 1;
                dir_log.push_back(1'b0);
                if (model_en) out_rd <= out_rd + 1;
                if (DB_T != 8'hFF || SLOE || FIFOADR != 2'b00) viol <= viol + 1;
            end
            if (!SLWR) begin
                wr_cnt      <= wr_cnt + 1;
                last_wr_cyc <= cyc;
                wr_log.push_back(DB_O);
                dir_log.push_back(1'b1);
                if (DB_T != 8'h00 || FIFOADR != 2'b10) viol <= viol + 1;
            end
            if (!PKTEND) begin
                pkt_cnt      <= pkt_cnt + 1;
                last_pkt_cyc <= cyc;
                if (DB_T != 8'h00 || FIFOADR != 2'b10 || prev_pkt_low) viol <= viol + 1;
            end
            if (int'(!SLRD) + int'(!SLWR) + int'(!PKTEND) > 1) viol <= viol + 1;
            if (rx_valid && rx_ready) rx_log.push_back(rx_data);
            if (tx_valid && tx_ready) tx_rd <= tx_rd + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] wr_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_log.size()) return rx_log[i];
        return 8'hxx;
    endfunction

    task automatic push_out(input logic [7:0] b);
        out_mem[out_wr % 64] = b;
        out_wr++;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_wr % 64] = b;
        tx_wr++;
    endtask

    // Waits until the engine has started and then stayed IDLE for four cycles.
    task automatic wait_quiet(input string name);
        int idle_run = 0;
        int n = 0;
        repeat (2) @(negedge IFCLK);
        while (idle_run < 4 && n < 400) begin
            @(negedge IFCLK);
            n++;
            if (!busy) idle_run++;
            else idle_run = 0;
        end
        check({name, " settle"}, 64'(idle_run >= 4), 64'd1);
    endtask

    typedef struct {
        logic       flaga;
        logic [7:0] db_i;
        logic       slrd;
        logic       sloe;
        logic       rx_valid;
        logic [7:0] rx_data;
        logic       busy;
    } vec_t;

    initial begin
        vec_t tbl [10];
        int   base_rd, base_wr, base_rx, base_pkt, base_dir;
        int   errs, n, k;

        // Three-byte read: IDLE, TURN, then strobe/gap pairs, exit on FLAGA.
        tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1};
        tbl[5] = '{1'b0, 8'hA2, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1};
        tbl[6] = '{1'b0, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1};
        tbl[7] = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 8'hA2, 1'b1};
        tbl[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1};
        tbl[9] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b0};

        RST = 1'b1; EPPRST = 1'b0; STMEN = 1'b1;
        model_en = 1'b0; flaga_tb = 1'b1; flagb_tb = 1'b1; db_i_tb = 8'h00;
        limit_en = 1'b0; wr_limit = 0; tx_en = 1'b0; rx_ready = 1'b1; tx_flush = 1'b0;

        repeat (3) @(negedge IFCLK);
        check("reset strobes", {SLRD, SLWR, SLOE, PKTEND}, 4'hF);
        check("reset FIFOADR", FIFOADR, 2'b00);
        check("reset DB_O", DB_O, 8'h00);
        check("reset DB_T", DB_T, 8'hFF);
        check("reset rx", {rx_valid, rx_data}, 9'h000);
        check("reset tx_ready", tx_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge IFCLK);
            flaga_tb = tbl[i].flaga;
            db_i_tb  = tbl[i].db_i;
            #1;
            check($sformatf("read vec %0d", i),
                  {SLRD, SLOE, FIFOADR, rx_valid, rx_data, busy, DB_T},
                  {tbl[i].slrd, tbl[i].sloe, 2'b00, tbl[i].rx_valid, tbl[i].rx_data, tbl[i].busy, 8'hFF});
        end

        // Write path: 16 bytes, carried in BURST-sized bursts.
        @(negedge IFCLK);
        model_en = 1'b1; flagb_tb = 1'b0; tx_en = 1'b1;
        base_wr = wr_cnt; base_pkt = pkt_cnt;
        for (int i = 0; i < 16; i++) push_tx(8'h10 + 8'(i));
        wait_quiet("write");
        check("write count", 64'(wr_cnt - base_wr), 64'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("write byte %0d", i), wr_at(base_wr + i), 8'h10 + 8'(i));
        check("write idle DB_T", DB_T, 8'hFF);
        check("write no PKTEND", 64'(pkt_cnt - base_pkt), 64'd0);

        // Contention: both directions pending, alternating bursts starting with RX (last was TX).
        @(negedge IFCLK);
        base_dir = dir_log.size(); base_rx = rx_log.size(); base_wr = wr_log.size();
        for (int i = 0; i < 12; i++) begin
            push_out(8'hB0 + 8'(i));
            push_tx(8'hC0 + 8'(i));
        end
        wait_quiet("contention");
        check("contention strobes", 64'(dir_log.size() - base_dir), 64'd24);
        errs = 0;
        for (int i = 0; i < 24; i++) begin
            if (base_dir + i >= dir_log.size() || dir_log[base_dir + i] != 1'((i / BURST) % 2)) errs++;
        end
        check("contention burst order", 64'(errs), 64'd0);
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            if (rx_at(base_rx + i) !== 8'hB0 + 8'(i)) errs++;
            if (wr_at(base_wr + i) !== 8'hC0 + 8'(i)) errs++;
        end
        check("contention data", 64'(errs), 64'd0);

        // IN FIFO fills after two writes, then drains.
        @(negedge IFCLK);
        base_wr = wr_cnt;
        wr_limit = wr_cnt + 2; limit_en = 1'b1;
        for (int i = 0; i < 4; i++) push_tx(8'hD0 + 8'(i));
        repeat (20) @(negedge IFCLK);
        check("full stops writes", 64'(wr_cnt - base_wr), 64'd2);
        check("full tx_ready", tx_ready, 1'b0);
        check("full SLWR idle", SLWR, 1'b1);
        limit_en = 1'b0;
        wait_quiet("full resume");
        check("full resume count", 64'(wr_cnt - base_wr), 64'd4);
        errs = 0;
        for (int i = 0; i < 4; i++) if (wr_at(base_wr + i) !== 8'hD0 + 8'(i)) errs++;
        check("full resume data", 64'(errs), 64'd0);

        // Consumer stalls: exactly one byte read and held.
        @(negedge IFCLK);
        rx_ready = 1'b0;
        base_rd = rd_cnt; base_rx = rx_log.size();
        for (int i = 0; i < 3; i++) push_out(8'hE0 + 8'(i));
        repeat (20) @(negedge IFCLK);
        check("stall one read", 64'(rd_cnt - base_rd), 64'd1);
        check("stall held byte", {rx_valid, rx_data}, {1'b1, 8'hE0});
        check("stall SLRD idle", {SLRD, SLOE, busy}, 3'b110);
        rx_ready = 1'b1;
        wait_quiet("stall resume");
        check("stall resume count", 64'(rd_cnt - base_rd), 64'd3);
        errs = 0;
        for (int i = 0; i < 3; i++) if (rx_at(base_rx + i) !== 8'hE0 + 8'(i)) errs++;
        check("stall resume data", 64'(errs), 64'd0);

        // Flush during a three-byte write: PKTEND right after the gap following the last SLWR.
        @(negedge IFCLK);
        base_wr = wr_cnt; base_pkt = pkt_cnt;
        for (int i = 0; i < 3; i++) push_tx(8'hF0 + 8'(i));
        repeat (3) @(negedge IFCLK);
        tx_flush = 1'b1;
        @(negedge IFCLK);
        tx_flush = 1'b0;
        wait_quiet("flush write");
        check("flush write count", 64'(wr_cnt - base_wr), 64'd3);
        check("flush pulse count", 64'(pkt_cnt - base_pkt), 64'd1);
        check("flush after last SLWR", 64'(last_pkt_cyc - last_wr_cyc), 64'd2);

        // Zero-length packet from IDLE.
        @(negedge IFCLK);
        base_wr = wr_cnt; base_pkt = pkt_cnt;
        tx_flush = 1'b1;
        @(negedge IFCLK);
        tx_flush = 1'b0;
        wait_quiet("flush zlp");
        check("zlp pulse count", 64'(pkt_cnt - base_pkt), 64'd1);
        check("zlp no SLWR", 64'(wr_cnt - base_wr), 64'd0);

        // Abort during the second strobe of a read burst.
        @(negedge IFCLK);
        base_rd = rd_cnt; base_rx = rx_log.size();
        for (int i = 0; i < 4; i++) push_out(8'h60 + 8'(i));
        n = 0; k = 0;
        while (n < 2 && k < 100) begin
            @(negedge IFCLK);
            k++;
            if (!SLRD) n++;
        end
        check("abort strobe seen", 64'(n), 64'd2);
        EPPRST = 1'b1; rx_ready = 1'b0;
        @(negedge IFCLK);
        check("abort strobes released", {SLRD, SLOE, SLWR, PKTEND}, 4'hF);
        check("abort DB_T", DB_T, 8'hFF);
        check("abort busy", busy, 1'b0);
        check("abort held byte", {rx_valid, rx_data}, {1'b1, 8'h61});
        repeat (5) @(negedge IFCLK);
        check("abort no reads", 64'(rd_cnt - base_rd), 64'd2);
        check("abort byte kept", {rx_valid, rx_data}, {1'b1, 8'h61});
`ifdef DSTM_BYTE_COUNT_EN
        check("rx_count", 64'(rx_count), 64'(rd_cnt));
        check("tx_count", 64'(tx_count), 64'(wr_cnt));
`endif
        EPPRST = 1'b0; rx_ready = 1'b1;
        wait_quiet("abort resume");
        check("abort resume count", 64'(rd_cnt - base_rd), 64'd4);
        errs = 0;
        for (int i = 0; i < 4; i++) if (rx_at(base_rx + i) !== 8'h60 + 8'(i)) errs++;
        check("abort resume data", 64'(errs), 64'd0);

        check("bus protocol violations", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dstm_fifo_engine.md
Name: dstm_fifo_engine

Overview:
- Synchronous slave-FIFO stream engine for the FX2 USB controller.
- Drives the DSTM-side port of the EPP/DSTM mux: SLRD, SLWR, SLOE, FIFOADR, PKTEND, DB_O/DB_T. Samples FLAGA/FLAGB and DB_I.
- Converts the USB FIFO traffic into two internal byte streams (valid/ready): rx (host to FPGA) and tx (FPGA to host).
- Arbitrates between the two directions in bounded bursts and issues short-packet commits.

Parameters:
- BURST_LEN, 16: max bytes moved in one direction before re-arbitration; range 1..255.
- TURN_CYCLES, 1: idle cycles with DB_T=8'hFF inserted on every direction change; range 1..3.

Ports:
- IFCLK  in  1  FX2 interface clock; all logic on the rising edge.
- RST  in  1  asynchronous active-high reset.
- EPPRST  in  1  EPP mode select; 1 forces the engine idle.
- STMEN  in  1  stream enable; 0 blocks new transfers.
- FLAGA  in  1  1 = OUT FIFO empty.
- FLAGB  in  1  1 = IN FIFO full.
- SLRD  out  1  active-low read strobe.
- SLWR  out  1  active-low write strobe.
- SLOE  out  1  active-low FIFO output enable.
- FIFOADR  out  2  00 = OUT FIFO, 10 = IN FIFO.
- PKTEND  out  1  active-low packet commit.
- DB_I  in  8  FIFO data in.
- DB_O  out  8  FIFO data out.
- DB_T  out  8  per-bit tristate; 1 = input.
- rx_data  out  8  byte read from the OUT FIFO.
- rx_valid  out  1  rx_data is valid.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  8  byte to write to the IN FIFO.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  engine accepts tx_data.
- tx_flush  in  1  one-cycle pulse requesting a PKTEND commit.
- busy  out  1  state other than IDLE.

Behaviour:
Reset values (RST=1):
- SLRD, SLWR, SLOE, PKTEND = 1.
- FIFOADR = 2'b00; DB_O = 8'h00; DB_T = 8'hFF.
- rx_valid = 0; rx_data = 0; tx_ready = 0; busy = 0.
- state = IDLE; burst counter = 0; flush_pend = 0; last_dir = TX.

Go condition: go = STMEN & ~EPPRST.

States: IDLE, TURN, RD, WR, FLUSH.

IDLE:
- rd_req = go & ~FLAGA & ~rx_valid.
- wr_req = go & ~FLAGB & (tx_valid | flush_pend).
- Round-robin arbitration: if both requests are active, serve the direction opposite to last_dir.
- Move to TURN with the chosen target direction and set last_dir.

TURN:
- DB_T = FF.
- FIFOADR is set to the target (00 for RD, 10 for WR).
- For RD, SLOE goes low at TURN entry.
- Count TURN_CYCLES cycles, then enter RD or WR.
- Burst counter cleared on entry.

RD (1 byte per 2 cycles):
- Strobe cycle, entered when ~FLAGA & ~rx_valid & SLRD==1 & ~gap: drive SLRD=0. At the end of that edge, rx_data<=DB_I, rx_valid<=1, increment the counter, set gap.
- Gap cycle: SLRD=1 and no strobe.
- Leave to IDLE, restoring SLOE=1, when any of these holds: FLAGA=1, counter==BURST_LEN, ~go, or rx_valid still held when the next strobe is due.

rx handshake:
- rx_valid stays high until rx_valid & rx_ready, independent of state.
- The held byte survives EPPRST and STMEN=0; it is lost only on RST.

WR:
- DB_T = 00.
- tx_ready = (state==WR) & ~FLAGB & SLWR & ~gap & go.
- On tx_valid & tx_ready: DB_O<=tx_data, SLWR<=0 for exactly one cycle, increment the counter. Next cycle has SLWR=1 as the gap.
- Leave when any of these holds: FLAGB=1, counter==BURST_LEN, ~go, or ~tx_valid.
- Exit goes to FLUSH if flush_pend, else IDLE.
- DB_T returns to FF on IDLE entry.

FLUSH:
- FIFOADR = 10; PKTEND=0 for one cycle; clear flush_pend; go to IDLE.
- A flush with no pending data still issues PKTEND (zero-length packet).

tx_flush:
- Sets flush_pend; the pulse is latched in any state.
- A pulse in the same cycle as flush_pend clear keeps it set.

Strobe exclusivity: SLRD, SLWR and PKTEND are never low simultaneously, and are never low while DB_T mismatches the direction.

EPPRST or STMEN falling mid-operation:
- An active strobe cycle completes.
- Next state is IDLE; all strobes and SLOE go to 1; DB_T = FF.
- flush_pend is kept.

Optional Feature:
Macro DSTM_BYTE_COUNT_EN.
- When defined, adds two ports: rx_count out 32 and tx_count out 32.
- rx_count increments on each SLRD strobe; tx_count increments on each SLWR strobe.
- Both wrap modulo 2^32 and reset to 0 on RST.
- Counting is not cleared by EPPRST.
- When undefined, neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
1. Read path: FLAGA=0 with 3 bytes A1,A2,A3 queued, then FLAGA=1, rx_ready=1 -> expect SLOE=0, FIFOADR=00, three 1-cycle SLRD pulses 2 cycles apart, rx_data A1,A2,A3 in order, then return to IDLE with SLOE=1.
2. Write path: tx stream 10..1F (16 bytes), BURST_LEN=16, FLAGB=0 -> expect 16 SLWR pulses carrying DB_O=10..1F with DB_T=00, then IDLE and DB_T=FF.
3. Contention: rd_req and wr_req held continuously with BURST_LEN=4 -> expect alternating 4-byte bursts, each separated by TURN_CYCLES cycles with DB_T=FF and no strobe.
4. Full/backpressure:
   - FLAGB rises after 2 writes -> tx_ready=0, no further SLWR; resumes when FLAGB=0.
   - rx_ready=0 -> exactly one byte read, SLRD idle until the byte is accepted.
5. Flush: tx_flush pulsed during a 3-byte write -> expect PKTEND=0 for one cycle after the last SLWR with FIFOADR=10; a flush from IDLE -> PKTEND pulse with no SLWR.
6. Abort: EPPRST=1 mid-read burst -> next cycle SLRD, SLOE, SLWR = 1 and DB_T=FF; the held rx byte remains valid; with DSTM_BYTE_COUNT_EN, rx_count equals the number of SLRD pulses.
